uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter and sequencer that shares one byte-level UART transmitter among NREQ requesters. Each requester presents bytes with a valid/ready handshake and a last flag. A grant is held for a whole multi-byte packet, so a message such as "G0" is never interleaved. The block sits between application logic (key handlers, status reporters) and the UART TX serializer, and it drives that serializer's start/data inputs.

## Interface
- NREQ, 4: number of requesters, 2..8
- GW, 2: grant index width, ceil(log2(NREQ))
- WDOG_CYC, 65535: watchdog limit in clk cycles while waiting for tx_done (16-bit counter)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  byte for requester i at [8i+7:8i]
- req_last  in  NREQ  byte is the final byte of its packet
- req_ready  out  NREQ  one-cycle accept pulse, at most one bit set
- tx_start  out  1  one-cycle start pulse to the serializer
- tx_data  out  8  byte to the serializer, stable from tx_start until tx_done
- tx_busy  in  1  serializer busy; a new start is not issued while high
- tx_done  in  1  one-cycle pulse when the stop bit completes
- grant_id  out  GW  index of the current or last granted requester
- locked  out  1  packet in progress; grant held
- err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, LOAD, WAIT, HOLD.
- IDLE:
  - If any req_valid is set and tx_busy=0, select the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - In the same cycle: pulse req_ready[sel], latch req_data[sel] into tx_data, latch req_last[sel] into last_q, set grant_id=sel and locked=1, then go to LOAD.
- LOAD: assert tx_start for exactly one cycle, clear the watchdog counter, go to WAIT.
- WAIT: on tx_done:
  - If last_q=1: set locked=0 and rr_ptr=(grant_id+1) mod NREQ, go to IDLE.
  - If last_q=0: go to HOLD.
- HOLD:
  - Only req_valid[grant_id] is considered. Other requesters are ignored even if valid.
  - When it is high and tx_busy=0, accept as in IDLE (ready pulse, latch data/last), go to LOAD.
- rr_ptr resets to 0 and updates only on packet release.
- tx_busy=1 in IDLE or HOLD stalls acceptance. No req_ready is issued.
- tx_done outside WAIT is ignored.
- req_valid dropped before acceptance is legal; nothing is latched.
- Reset mid-operation: every state is cleared immediately, with no tx_start. The serializer is reset by the same rst_n.

## Timing
- Reset values:
  - Outputs: req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, locked=0, err=0.
  - Internal: state=IDLE, rr_ptr=0, last_q=0, watchdog=0.
- Latency: req_valid sampled high in IDLE → req_ready on that same edge (registered). tx_start follows 1 cycle later.
- Byte-to-byte gap inside a packet: tx_done → HOLD (1 cycle) → accept (≥1 cycle) → tx_start. That is at least 3 clk between tx_done and the next tx_start.
- If tx_done arrives in the same cycle the watchdog reaches WDOG_CYC-1, tx_done wins. No err is raised.
- Simultaneous valid from all requesters: each is served once per round when every packet is a single byte.

## Configuration
- UART_ARB_WDOG_EN defined:
  - In WAIT, a 16-bit counter increments each cycle.
  - At WDOG_CYC-1 without tx_done: pulse err for 1 cycle, set locked=0, set rr_ptr=grant_id+1, go to IDLE. Any remaining bytes of the packet are dropped by the requester's own logic.
- Not defined:
  - No counter is present, and WAIT persists until tx_done.
  - err is tied to 0.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 → all outputs at their reset values, no req_ready. Release → first grant goes to index 0.
- Single byte: req 2 sends 8'h47 with last=1 → req_ready[2] pulse, tx_start one cycle later with tx_data=8'h47. After tx_done: locked=0 and rr_ptr=3.
- Packet lock: req 0 sends "G","0" (8'h47, 8'h30, last on the second) while req 1 is valid throughout → the serializer sees 47 then 30, and req 1 is granted only after the second tx_done.
- Round-robin: all four requesters valid with single-byte packets 8'hA0..A3 → tx_data order is A0, A1, A2, A3, then A0 again.
- Busy stall: tx_busy=1 for 20 cycles while req 3 is valid → no req_ready until tx_busy falls, then the accept follows on the next edge.
- Watchdog (UART_ARB_WDOG_EN, WDOG_CYC=100): no tx_done after tx_start → err pulses 100 cycles after WAIT entry, locked=0, and the next valid requester is granted.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX serializer; grant is held for a whole packet.
// Optional watchdog on tx_done enabled by defining UART_ARB_WDOG_EN.
module uart_tx_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned GW       = 2,
    parameter int unsigned WDOG_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic [GW-1:0]     grant_id,
    output logic              locked,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic            locked_q, locked_d;
    logic            last_q, last_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

`ifdef UART_ARB_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);
    logic [15:0]     wdog_q, wdog_d;
    logic            err_q, err_d;
`else
    logic            unused_wdog_cfg;
    assign unused_wdog_cfg = ^WDOG_CYC;
`endif

    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic [GW:0]     rr_sum;
    logic [GW-1:0]   rr_next;
    logic            do_accept;
    logic [GW-1:0]   acc_idx;
    logic [7:0]      acc_byte;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_sum    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (rr_sum >= (GW+1)'(NREQ)) begin
                rr_sum = rr_sum - (GW+1)'(NREQ);
            end
            if (!sel_found && req_valid[rr_sum[GW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = rr_sum[GW-1:0];
            end
        end
    end

    assign rr_next  = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign acc_idx  = (state_q == HOLD) ? grant_id_q : sel_idx;
    assign acc_byte = 8'(req_data >> {acc_idx, 3'b000});

    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        locked_d    = locked_q;
        last_d      = last_q;
        rr_ptr_d    = rr_ptr_q;
        do_accept   = 1'b0;
`ifdef UART_ARB_WDOG_EN
        wdog_d      = wdog_q;
        err_d       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                do_accept = sel_found && !tx_busy;
            end
            LOAD: begin
                tx_start_d = 1'b1;
                state_d    = WAIT;
`ifdef UART_ARB_WDOG_EN
                wdog_d     = '0;
`endif
            end
            WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        locked_d = 1'b0;
                        rr_ptr_d = rr_next;
                        state_d  = IDLE;
                    end else begin
                        state_d  = HOLD;
                    end
                end
`ifdef UART_ARB_WDOG_EN
                else if (wdog_q == WDOG_LAST) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end else begin
                    wdog_d   = wdog_q + 16'd1;
                end
`endif
            end
            HOLD: begin
                // Only the packet owner may continue; other requesters wait
                do_accept = req_valid[grant_id_q] && !tx_busy;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_accept) begin
            req_ready_d[acc_idx] = 1'b1;
            tx_data_d            = acc_byte;
            last_d               = req_last[acc_idx];
            grant_id_d           = acc_idx;
            locked_d             = 1'b1;
            state_d              = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            grant_id_q  <= '0;
            locked_q    <= 1'b0;
            last_q      <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            grant_id_q  <= grant_id_d;
            locked_q    <= locked_d;
            last_q      <= last_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef UART_ARB_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: cycle table plus hand-written stall, reset and watchdog sequences.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        locked;
    logic        err;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] D_RR = 32'hA3A2_A1A0;
    localparam logic [31:0] D_P1 = 32'h0000_3147;
    localparam logic [31:0] D_P2 = 32'h0000_3130;
    localparam logic [31:0] D_S  = 32'h5A47_0000;

    uart_tx_arb #(
        .NREQ(4),
        .GW(2),
        .WDOG_CYC(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .grant_id(grant_id),
        .locked(locked),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        busy;
        logic        done;
        logic [3:0]  ready;
        logic        start;
        logic [7:0]  txd;
        logic [1:0]  gid;
        logic        lock;
        logic        e;
    } vec_t;

    vec_t tbl[$];
    vec_t t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic busy, input logic done,
                                input logic [3:0] ready, input logic start, input logic [7:0] txd,
                                input logic [1:0] gid, input logic lock, input logic e);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.busy = busy; r.done = done;
        r.ready = ready; r.start = start; r.txd = txd; r.gid = gid; r.lock = lock; r.e = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                        input logic busy, input logic done);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        tx_busy   = busy;
        tx_done   = done;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {15'b0, req_ready, tx_start, tx_data, grant_id, locked, err};
    endfunction

    function automatic logic [31:0] exp_of(input vec_t x);
        return {15'b0, x.ready, x.start, x.txd, x.gid, x.lock, x.e};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;

        // Round robin over all four single-byte requesters, wrapping back to 0
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h1, 0, 8'hA0, 2'd0, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h0, 1, 8'hA0, 2'd0, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 1, 0, 4'h0, 0, 8'hA0, 2'd0, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 1, 1, 4'h0, 0, 8'hA0, 2'd0, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h2, 0, 8'hA1, 2'd1, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h0, 1, 8'hA1, 2'd1, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 1, 4'h0, 0, 8'hA1, 2'd1, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h4, 0, 8'hA2, 2'd2, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h0, 1, 8'hA2, 2'd2, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 1, 4'h0, 0, 8'hA2, 2'd2, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h8, 0, 8'hA3, 2'd3, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h0, 1, 8'hA3, 2'd3, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 1, 4'h0, 0, 8'hA3, 2'd3, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h1, 0, 8'hA0, 2'd0, 1, 0));
        // tx_done during LOAD must not end the byte
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 1, 4'h0, 1, 8'hA0, 2'd0, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 0, 4'h0, 0, 8'hA0, 2'd0, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_RR, 0, 1, 4'h0, 0, 8'hA0, 2'd0, 0, 0));
        // Packet "G0" from req 0 with req 1 pending; rr_ptr is 1 here
        tbl.push_back(mk(4'h1, 4'h0, D_P1, 0, 0, 4'h1, 0, 8'h47, 2'd0, 1, 0));
        tbl.push_back(mk(4'h3, 4'h0, D_P1, 0, 0, 4'h0, 1, 8'h47, 2'd0, 1, 0));
        tbl.push_back(mk(4'h3, 4'h0, D_P1, 0, 1, 4'h0, 0, 8'h47, 2'd0, 1, 0));
        tbl.push_back(mk(4'h2, 4'h3, D_P2, 0, 0, 4'h0, 0, 8'h47, 2'd0, 1, 0));
        tbl.push_back(mk(4'h3, 4'h3, D_P2, 1, 0, 4'h0, 0, 8'h47, 2'd0, 1, 0));
        tbl.push_back(mk(4'h3, 4'h3, D_P2, 0, 0, 4'h1, 0, 8'h30, 2'd0, 1, 0));
        tbl.push_back(mk(4'h3, 4'h3, D_P2, 0, 0, 4'h0, 1, 8'h30, 2'd0, 1, 0));
        tbl.push_back(mk(4'h3, 4'h3, D_P2, 0, 1, 4'h0, 0, 8'h30, 2'd0, 0, 0));
        tbl.push_back(mk(4'h2, 4'h3, D_P2, 0, 0, 4'h2, 0, 8'h31, 2'd1, 1, 0));
        tbl.push_back(mk(4'h0, 4'h0, D_P2, 0, 0, 4'h0, 1, 8'h31, 2'd1, 1, 0));
        tbl.push_back(mk(4'h0, 4'h0, D_P2, 0, 1, 4'h0, 0, 8'h31, 2'd1, 0, 0));
        // Busy in IDLE stalls, then valid withdrawn before acceptance
        tbl.push_back(mk(4'h8, 4'hF, D_RR, 1, 0, 4'h0, 0, 8'h31, 2'd1, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, D_RR, 0, 0, 4'h0, 0, 8'h31, 2'd1, 0, 0));
        // Single byte 47 from req 2; the next grant with all valid must be req 3
        tbl.push_back(mk(4'h4, 4'hF, D_S, 0, 0, 4'h4, 0, 8'h47, 2'd2, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_S, 0, 0, 4'h0, 1, 8'h47, 2'd2, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_S, 1, 0, 4'h0, 0, 8'h47, 2'd2, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_S, 1, 1, 4'h0, 0, 8'h47, 2'd2, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, D_S, 0, 0, 4'h8, 0, 8'h5A, 2'd3, 1, 0));
        tbl.push_back(mk(4'h0, 4'hF, D_S, 0, 0, 4'h0, 1, 8'h5A, 2'd3, 1, 0));
        tbl.push_back(mk(4'h0, 4'hF, D_S, 0, 1, 4'h0, 0, 8'h5A, 2'd3, 0, 0));

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = D_RR;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", outs(), 32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            step(t.v, t.l, t.d, t.busy, t.done);
            chk($sformatf("vec%0d", i), outs(), exp_of(t));
        end

        // tx_busy held for 20 cycles with req 3 valid; rr_ptr is 0
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(4'h8, 4'hF, D_S, 1, 0);
            if (req_ready !== 4'h0 || locked !== 1'b0) seen = 1'b1;
        end
        chk("busy_stall_no_ready", {31'b0, seen}, 32'h0);
        step(4'h8, 4'hF, D_S, 0, 0);
        chk("busy_release_accept", outs(), {15'b0, 4'h8, 1'b0, 8'h5A, 2'd3, 1'b1, 1'b0});
        step(4'h0, 4'hF, D_S, 0, 0);
        chk("busy_release_start", {31'b0, tx_start}, 32'h1);
        step(4'h0, 4'hF, D_S, 0, 1);
        chk("busy_release_done", {31'b0, locked}, 32'h0);

        // Asynchronous reset while waiting on the serializer
        step(4'h4, 4'hF, D_S, 0, 0);
        chk("rst_mid_accept", {28'b0, req_ready}, 32'h4);
        step(4'hF, 4'hF, D_S, 0, 0);
        step(4'hF, 4'hF, D_S, 1, 0);
        chk("rst_mid_pre", {30'b0, grant_id, locked}, {29'b0, 2'd2, 1'b1});
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_async", outs(), 32'h0);
        step(4'hF, 4'hF, D_RR, 0, 0);
        chk("rst_mid_held1", outs(), 32'h0);
        step(4'hF, 4'hF, D_RR, 0, 1);
        chk("rst_mid_held2", outs(), 32'h0);
        rst_n = 1'b1;
        step(4'hF, 4'hF, D_RR, 0, 0);
        chk("rst_mid_first_grant", outs(), {15'b0, 4'h1, 1'b0, 8'hA0, 2'd0, 1'b1, 1'b0});
        step(4'h0, 4'hF, D_RR, 0, 0);
        step(4'h0, 4'hF, D_RR, 0, 1);
        chk("rst_mid_release", {31'b0, locked}, 32'h0);

`ifdef UART_ARB_WDOG_EN
        // No tx_done: err must pulse 100 cycles after entering WAIT
        step(4'h2, 4'hF, D_RR, 0, 0);
        chk("wdog_accept", {30'b0, grant_id}, 32'd1);
        step(4'h0, 4'hF, D_RR, 0, 0);
        chk("wdog_start", {31'b0, tx_start}, 32'h1);
        n = 0;
        for (int k = 1; k <= 150; k++) begin
            step(4'h0, 4'hF, D_RR, 1, 0);
            if (err === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("wdog_err_cycle", n, 32'd100);
        chk("wdog_unlock", {31'b0, locked}, 32'h0);
        step(4'h0, 4'hF, D_RR, 0, 0);
        chk("wdog_err_pulse", {31'b0, err}, 32'h0);
        step(4'hF, 4'hF, D_RR, 0, 0);
        chk("wdog_next_grant", outs(), {15'b0, 4'h4, 1'b0, 8'hA2, 2'd2, 1'b1, 1'b0});
        step(4'h0, 4'hF, D_RR, 0, 0);
        // tx_done on the final watchdog cycle wins
        seen = 1'b0;
        for (int k = 1; k <= 99; k++) begin
            step(4'h0, 4'hF, D_RR, 1, 0);
            if (err !== 1'b0 || locked !== 1'b1) seen = 1'b1;
        end
        chk("wdog_no_early_err", {31'b0, seen}, 32'h0);
        step(4'h0, 4'hF, D_RR, 1, 1);
        chk("wdog_done_wins", {30'b0, locked, err}, 32'h0);
        step(4'h0, 4'hF, D_RR, 0, 0);
        chk("wdog_done_wins_after", {31'b0, err}, 32'h0);
`else
        // Without the watchdog WAIT persists indefinitely and err stays low
        step(4'h2, 4'hF, D_RR, 0, 0);
        chk("nowdog_accept", {30'b0, grant_id}, 32'd1);
        step(4'h0, 4'hF, D_RR, 0, 0);
        seen = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            step(4'h0, 4'hF, D_RR, 1, 0);
            if (err !== 1'b0 || locked !== 1'b1 || req_ready !== 4'h0) seen = 1'b1;
        end
        chk("nowdog_wait_persists", {31'b0, seen}, 32'h0);
        step(4'h0, 4'hF, D_RR, 0, 1);
        chk("nowdog_release", {30'b0, locked, err}, 32'h0);
        step(4'hF, 4'hF, D_RR, 0, 0);
        chk("nowdog_next_grant", outs(), {15'b0, 4'h4, 1'b0, 8'hA2, 2'd2, 1'b1, 1'b0});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
